// File: rtl/point_assembler.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | point_assembler                                                             |
// | Packs DIM serial coordinates into one point, flagging coord_last framing    |
// | errors. Optional stats counters when POINT_ASSEMBLER_STATS_EN is defined.   |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module point_assembler #(
    parameter int DIM     = 2,
    parameter int COORD_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   coord_valid,
    output logic                   coord_ready,
    input  logic [COORD_W-1:0]     coord_data,
    input  logic                   coord_last,
    output logic                   pt_valid,
    input  logic                   pt_ready,
    output logic [DIM*COORD_W-1:0] pt_data,
    output logic                   pt_err
`ifdef POINT_ASSEMBLER_STATS_EN
    ,
    output logic [15:0]            pt_count,
    output logic [15:0]            err_count,
    output logic [15:0]            drop_count
`endif
);

    localparam int IDX_W = (DIM > 1) ? $clog2(DIM) : 1;
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(DIM - 1);

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        DISCARD = 1'b1
    } state_t;

    state_t                   r_state;
    logic [IDX_W-1:0]         r_idx;
    logic [COORD_W-1:0]       r_buf [DIM];
    logic                     r_pending;
    logic                     r_pend_err;
    logic                     r_pt_valid;
    logic [DIM*COORD_W-1:0]   r_pt_data;
    logic                     r_pt_err;

    logic                     w_coord_fire;
    logic                     w_pt_fire;
    logic                     w_out_free;
    logic                     w_at_last;
    logic                     w_complete;
    logic                     w_err;
    logic [DIM*COORD_W-1:0]   w_assembled;
    logic [DIM*COORD_W-1:0]   w_buf_packed;

    assign coord_ready  = !r_pending;
    assign pt_valid     = r_pt_valid;
    assign pt_data      = r_pt_data;
    assign pt_err       = r_pt_err;

    assign w_coord_fire = coord_valid && !r_pending;
    assign w_pt_fire    = r_pt_valid && pt_ready;
    assign w_out_free   = !r_pt_valid || pt_ready;
    assign w_at_last    = (r_idx == c_last_idx);
    assign w_complete   = w_at_last || coord_last;
    // Error when framing and DIM disagree: early last, or missing last at the final slot
    assign w_err        = (w_at_last != coord_last);

    // Point as it would look with the incoming coordinate written to the current slot
    always_comb begin
        w_assembled  = '0;
        w_buf_packed = '0;
        for (int i = 0; i < DIM; i++) begin
            w_buf_packed[i*COORD_W +: COORD_W] = r_buf[i];
            w_assembled[i*COORD_W +: COORD_W]  =
                (r_idx == IDX_W'(i)) ? coord_data : r_buf[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= COLLECT;
            r_idx      <= '0;
            r_pending  <= 1'b0;
            r_pend_err <= 1'b0;
            r_pt_valid <= 1'b0;
            r_pt_data  <= '0;
            r_pt_err   <= 1'b0;
            for (int i = 0; i < DIM; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            if (w_pt_fire) begin
                r_pt_valid <= 1'b0;
            end

            // Stalled point moves out on the same edge the output drains
            if (r_pending && w_pt_fire) begin
                r_pt_valid <= 1'b1;
                r_pt_data  <= w_buf_packed;
                r_pt_err   <= r_pend_err;
                r_pending  <= 1'b0;
                for (int i = 0; i < DIM; i++) begin
                    r_buf[i] <= '0;
                end
            end

            if (w_coord_fire) begin
                if (r_state == COLLECT) begin
                    if (w_complete) begin
                        r_idx <= '0;
                        if (w_out_free) begin
                            r_pt_valid <= 1'b1;
                            r_pt_data  <= w_assembled;
                            r_pt_err   <= w_err;
                            for (int i = 0; i < DIM; i++) begin
                                r_buf[i] <= '0;
                            end
                        end else begin
                            for (int i = 0; i < DIM; i++) begin
                                if (r_idx == IDX_W'(i)) begin
                                    r_buf[i] <= coord_data;
                                end
                            end
                            r_pending  <= 1'b1;
                            r_pend_err <= w_err;
                        end
                        if (w_at_last && !coord_last) begin
                            r_state <= DISCARD;
                        end
                    end else begin
                        for (int i = 0; i < DIM; i++) begin
                            if (r_idx == IDX_W'(i)) begin
                                r_buf[i] <= coord_data;
                            end
                        end
                        r_idx <= r_idx + 1'b1;
                    end
                end else if (coord_last) begin
                    r_state <= COLLECT;
                end
            end
        end
    end

`ifdef POINT_ASSEMBLER_STATS_EN
    logic [15:0] r_pt_count;
    logic [15:0] r_err_count;
    logic [15:0] r_drop_count;

    assign pt_count   = r_pt_count;
    assign err_count  = r_err_count;
    assign drop_count = r_drop_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pt_count   <= '0;
            r_err_count  <= '0;
            r_drop_count <= '0;
        end else begin
            if (w_pt_fire && r_pt_count != 16'hFFFF) begin
                r_pt_count <= r_pt_count + 16'd1;
            end
            if (w_pt_fire && r_pt_err && r_err_count != 16'hFFFF) begin
                r_err_count <= r_err_count + 16'd1;
            end
            if (w_coord_fire && r_state == DISCARD && r_drop_count != 16'hFFFF) begin
                r_drop_count <= r_drop_count + 16'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_point_assembler.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_point_assembler                                                          |
// | Scoreboard bench driving DIM=3, DIM=2 and DIM=1 instances.                  |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module tb_point_assembler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] coord_data = '0;
    logic        coord_last = 1'b0;

    logic cv3 = 1'b0, cv2 = 1'b0, cv1 = 1'b0;
    logic cr3, cr2, cr1;
    logic pv3, pv2, pv1;
    logic pr3 = 1'b1, pr2 = 1'b1, pr1 = 1'b1;
    logic pe3, pe2, pe1;
    logic [95:0] pd3;
    logic [63:0] pd2;
    logic [31:0] pd1;

`ifdef POINT_ASSEMBLER_STATS_EN
    logic [15:0] pc3, ec3, dc3, pc2, ec2, dc2, pc1, ec1, dc1;
`endif

    int total = 0;
    int bad   = 0;
    int pops3 = 0;

    logic [96:0] q3[$];
    logic [64:0] q2[$];
    logic [32:0] q1[$];

    always #5 clk = ~clk;

    point_assembler #(.DIM(3), .COORD_W(32)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .coord_valid(cv3), .coord_ready(cr3),
        .coord_data(coord_data), .coord_last(coord_last), .pt_valid(pv3),
        .pt_ready(pr3), .pt_data(pd3), .pt_err(pe3)
`ifdef POINT_ASSEMBLER_STATS_EN
        , .pt_count(pc3), .err_count(ec3), .drop_count(dc3)
`endif
    );

    point_assembler #(.DIM(2), .COORD_W(32)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .coord_valid(cv2), .coord_ready(cr2),
        .coord_data(coord_data), .coord_last(coord_last), .pt_valid(pv2),
        .pt_ready(pr2), .pt_data(pd2), .pt_err(pe2)
`ifdef POINT_ASSEMBLER_STATS_EN
        , .pt_count(pc2), .err_count(ec2), .drop_count(dc2)
`endif
    );

    point_assembler #(.DIM(1), .COORD_W(32)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .coord_valid(cv1), .coord_ready(cr1),
        .coord_data(coord_data), .coord_last(coord_last), .pt_valid(pv1),
        .pt_ready(pr1), .pt_data(pd1), .pt_err(pe1)
`ifdef POINT_ASSEMBLER_STATS_EN
        , .pt_count(pc1), .err_count(ec1), .drop_count(dc1)
`endif
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy(input int sel);
        case (sel)
            3:       return cr3;
            2:       return cr2;
            default: return cr1;
        endcase
    endfunction

    // One coordinate per call; returns #1 after the accepting edge
    task automatic send(input int sel, input logic [31:0] d, input logic last);
        int n = 0;
        @(negedge clk);
        while (!rdy(sel) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            chk("send_timeout", 128'd1, 128'd0);
        end else begin
            coord_data = d;
            coord_last = last;
            case (sel)
                3:       cv3 = 1'b1;
                2:       cv2 = 1'b1;
                default: cv1 = 1'b1;
            endcase
            @(posedge clk);
            #1;
            cv3 = 1'b0; cv2 = 1'b0; cv1 = 1'b0;
            coord_last = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && pv3 && pr3) begin
            if (q3.size() == 0) chk("pt3_unexpected", 128'd1, 128'd0);
            else begin
                chk("pt3_point", {31'd0, pe3, pd3}, {31'd0, q3.pop_front()});
                pops3++;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && pv2 && pr2) begin
            if (q2.size() == 0) chk("pt2_unexpected", 128'd1, 128'd0);
            else chk("pt2_point", {63'd0, pe2, pd2}, {63'd0, q2.pop_front()});
        end
    end

    always @(negedge clk) begin
        if (rst_n && pv1 && pr1) begin
            if (q1.size() == 0) chk("pt1_unexpected", 128'd1, 128'd0);
            else chk("pt1_point", {95'd0, pe1, pd1}, {95'd0, q1.pop_front()});
        end
    end

    initial begin
        int base;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_ready", {cr3, cr2, cr1}, 3'b111);
        chk("reset_valid", {pv3, pv2, pv1}, 3'b000);
        chk("reset_data3", pd3, 96'd0);
        chk("reset_err",   {pe3, pe2, pe1}, 3'b000);

        // Nominal DIM=3
        q3.push_back({1'b0, 96'h00000008_00000007_00000006});
        send(3, 6, 0); send(3, 7, 0); send(3, 8, 1);
        chk("nominal_latency", pv3, 1'b1);
        chk("nominal_data", pd3, 96'h00000008_00000007_00000006);
        chk("nominal_err", pe3, 1'b0);

        // Short point then a good one
        q3.push_back({1'b1, 96'h00000000_00000005_00000004});
        send(3, 4, 0); send(3, 5, 1);
        chk("short_err", pe3, 1'b1);
        q3.push_back({1'b0, 96'h00000003_00000002_00000001});
        send(3, 1, 0); send(3, 2, 0); send(3, 3, 1);

        // Long point DIM=2
        q2.push_back({1'b1, 64'h00000004_00000003});
        q2.push_back({1'b0, 64'h00000008_00000007});
        send(2, 3, 0); send(2, 4, 0); send(2, 5, 0); send(2, 6, 1);
        send(2, 7, 0); send(2, 8, 1);
        chk("long_tail_data", pd2, 64'h00000008_00000007);
`ifdef POINT_ASSEMBLER_STATS_EN
        chk("long_drop_count", dc2, 16'd2);
`endif
        repeat (2) @(negedge clk);

        // Backpressure DIM=2
        @(posedge clk); #1 pr2 = 1'b0;
        q2.push_back({1'b0, 64'h00000002_00000001});
        q2.push_back({1'b0, 64'h00000004_00000003});
        send(2, 1, 0); send(2, 2, 1); send(2, 3, 0); send(2, 4, 1);
        chk("bp_ready_low", cr2, 1'b0);
        chk("bp_hold_data", pd2, 64'h00000002_00000001);
        @(negedge clk);
        chk("bp_ready_still_low", cr2, 1'b0);
        @(posedge clk); #1 pr2 = 1'b1;
        @(negedge clk);
        chk("bp_first", {pv2, pd2}, {1'b1, 64'h00000002_00000001});
        @(negedge clk);
        chk("bp_second", {pv2, pd2}, {1'b1, 64'h00000004_00000003});
        chk("bp_ready_back", cr2, 1'b1);

        // DIM=1 back-to-back
        q1.push_back({1'b0, 32'd9});
        q1.push_back({1'b0, 32'd10});
        q1.push_back({1'b0, 32'd11});
        send(1, 9, 1);
        chk("dim1_p0", {pv1, pd1}, {1'b1, 32'd9});
        send(1, 10, 1);
        chk("dim1_p1", {pv1, pd1}, {1'b1, 32'd10});
        send(1, 11, 1);
        chk("dim1_p2", {pv1, pd1}, {1'b1, 32'd11});
        repeat (3) @(negedge clk);

        // Reset mid-point DIM=3
        base = pops3;
        send(3, 1, 0); send(3, 2, 0);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_async_valid", pv3, 1'b0);
        chk("rst_async_data", pd3, 96'd0);
        chk("rst_async_err", pe3, 1'b0);
        @(posedge clk); #1 rst_n = 1'b1;
        q3.push_back({1'b0, 96'h00000007_00000006_00000005});
        send(3, 5, 0); send(3, 6, 0); send(3, 7, 1);
        repeat (5) @(negedge clk);
        chk("rst_one_point", pops3, base + 1);
        chk("queues_empty", {q3.size(), q2.size(), q1.size()}, 96'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/point_assembler.md
Name: point_assembler

Overview:
- Streaming stage directly upstream of the N-dimensional point consumer (Point populate/print path).
- Accepts a serial stream of coordinate words with valid/ready handshake.
- Groups DIM consecutive coordinates into one packed point and emits it with its own valid/ready handshake.
- Flags malformed points where the coord_last framing disagrees with DIM (too few or too many coordinates).

Parameters:
DIM, 2, coordinates per point; legal range 1..8.
COORD_W, 32, bits per coordinate (matches int).

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
coord_valid  in  1  upstream coordinate valid.
coord_ready  out  1  block can accept a coordinate.
coord_data  in  COORD_W  coordinate value.
coord_last  in  1  marks the final coordinate of a point.
pt_valid  out  1  packed point available.
pt_ready  in  1  downstream accepts the point.
pt_data  out  DIM*COORD_W  packed point; coordinate 0 in the LSBs.
pt_err  out  1  framing error on this point; qualified by pt_valid.

Behaviour:
- Reset (async assert, sync deassert by system): pt_valid=0, pt_data=0, pt_err=0. Collect buffer=0, idx=0, pending=0, state=COLLECT. coord_ready=1 in the first cycle after reset release.
- Transfers: a coordinate transfers when coord_valid&&coord_ready; a point transfers when pt_valid&&pt_ready.
- pt_data and pt_err hold stable while pt_valid=1 and pt_ready=0.
- Storage: a collect buffer (DIM slots, slot index idx 0..DIM-1) plus one output register, giving double buffering.
- State COLLECT, on each coordinate transfer:
  - Write coord_data to slot idx.
  - If idx<DIM-1 and coord_last=1: short point. Remaining slots are zero, the point completes, and err=1.
  - If idx==DIM-1 and coord_last=1: point completes with err=0.
  - If idx==DIM-1 and coord_last=0: long point. The point completes with err=1 and the FSM goes to DISCARD.
  - Otherwise: idx increments.
  - On completion, idx returns to 0.
- State DISCARD:
  - coord_ready=1 and accepted coordinates are dropped.
  - The transfer carrying coord_last=1 returns the FSM to COLLECT.
  - A stall caused by pending also holds DISCARD off, because coord_ready=0.
- Point completion handoff:
  - If the output register is empty, or is being drained in the same cycle, the collected point and err load into pt_data/pt_err and pt_valid=1 on the next edge.
  - Latency is one cycle from the last-coordinate transfer to pt_valid.
  - Otherwise pending=1 and the point stays in the collect buffer.
- coord_ready = !pending.
- While pending=1:
  - When the output drains, the pending point loads into the output on that same edge and pending clears.
  - coord_ready returns high in the next cycle.
- Simultaneous output drain and completion: the new point replaces the old one; pt_valid stays 1 with no bubble.
- Collect slots are cleared to 0 whenever a point leaves the collect buffer.
- DIM=1: every coordinate is a complete point. coord_last=0 gives err=1 plus DISCARD.
- Reset mid-point or mid-DISCARD: the partial point is discarded and no pt_valid is generated for it.
- No arithmetic on data: bits pass through unmodified. idx width is $clog2(DIM) with a minimum of 1.

Optional Feature:
- Macro POINT_ASSEMBLER_STATS_EN.
- When defined, adds these output ports:
  - pt_count (16 bits): increments on each point transfer.
  - err_count (16 bits): increments on each point transfer with pt_err=1.
  - drop_count (16 bits): increments on each coordinate dropped in DISCARD.
- All three counters saturate at 0xFFFF and reset to 0.
- When not defined, these ports and counters are absent and the remaining behaviour is identical.

Test Plan:
- Nominal: DIM=3, pt_ready=1, feed 6, 7, 8 (last on 8) back-to-back. Required: pt_valid one cycle after 8 is accepted, pt_data=0x00000008_00000007_00000006, pt_err=0.
- Short point: DIM=3, feed 4, 5 (last on 5). Required: pt_data=0x00000000_00000005_00000004, pt_err=1. A following 1, 2, 3(last) gives 0x00000003_00000002_00000001 with pt_err=0.
- Long point: DIM=2, feed 3, 4 (no last), 5, 6 (last), 7, 8 (last). Required: points {4,3} with err=1 and {8,7} with err=0. 5 and 6 are dropped; drop_count=2 when stats are enabled.
- Backpressure: DIM=2, pt_ready=0, feed 1, 2(last), 3, 4(last). Required: coord_ready=0 from the cycle after 4 is accepted. Raise pt_ready: {2,1} then {4,3} on consecutive cycles, no bubble, coord_ready high again after the handoff.
- DIM=1: feed 9(last), 10(last), 11(last) with pt_ready=1. Required: three points 9, 10, 11 on consecutive cycles, each with err=0.
- Reset mid-point: DIM=3, feed 1, 2, then pulse rst_n low asynchronously. Required: outputs are 0 immediately. After release, feed 5, 6, 7(last): exactly one point, 0x00000007_00000006_00000005, err=0.
